// File: rtl/intr_grant_sequencer.sv
// intr_grant_sequencer
// Registers the interrupt priority controller's grant outputs, filters them
// over a stability window, and presents one interrupt at a time to the CPU
// using a level irq / irq_ack handshake with ack timeout and post-ack holdoff.
module intr_grant_sequencer #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT   = 64,
    parameter int unsigned HOLDOFF       = 4
) (
    input  logic       CK,
    input  logic       RESET_N,
    input  logic [2:0] grant_bus,
    input  logic [3:0] grant_chan,
    input  logic       irq_ack,
    input  logic       err_clr,
    output logic       irq,
    output logic [5:0] irq_vec,
    output logic       busy,
    output logic       bad_code,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILTER  = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    // Elaboration-time constants sized to the counters they are compared with
    localparam logic       STABLE_ONE = (STABLE_CYCLES == 1) ? 1'b1 : 1'b0;
    localparam logic [3:0] STABLE_W   = 4'(STABLE_CYCLES);
    localparam logic       TO_EN      = (ACK_TIMEOUT != 0) ? 1'b1 : 1'b0;
    localparam logic [9:0] TO_LAST    = 10'(ACK_TIMEOUT - 1);
    localparam logic       HOLD_ZERO  = (HOLDOFF == 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] HOLD_LAST  = 4'(HOLDOFF - 1);

    // Lowest set grant bit wins: A (bit0) over B (bit1) over C (bit2)
    function automatic logic [1:0] bus_index(input logic [2:0] b);
        logic [1:0] idx;
        casez (b)
            3'b??1:  idx = 2'd0;
            3'b?10:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Registered input sample
    logic [2:0] bus_q;
    logic [3:0] chan_q;

    // FSM state and counters
    state_e     state_q, state_d;
    logic [5:0] cand_q,  cand_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [9:0] timer_q, timer_d;
    logic [3:0] hold_q,  hold_d;

    // Registered outputs
    logic       irq_q,   irq_d;
    logic [5:0] vec_q,   vec_d;
    logic       busy_q,  busy_d;
    logic       bad_q,   bad_d;
    logic       to_q,    to_d;

    // Decoded view of the registered sample
    logic       samp_any_s;
    logic       samp_illegal_s;
    logic       samp_valid_s;
    logic [5:0] samp_code_s;
    logic       to_set_s;

    // Classify the registered sample as none / illegal / valid candidate
    always_comb begin
        samp_any_s     = |bus_q;
        samp_illegal_s = samp_any_s && (chan_q > 4'd8);
        samp_valid_s   = samp_any_s && !samp_illegal_s;
        samp_code_s    = {bus_index(bus_q), chan_q};
    end

    // Next-state logic for the filter / assert / holdoff sequence
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        hold_d   = hold_q;
        to_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (samp_valid_s) begin
                    cand_d  = samp_code_s;
                    cnt_d   = 4'd1;
                    timer_d = 10'd0;
                    if (STABLE_ONE) begin
                        state_d = ST_ASSERT;
                    end else begin
                        state_d = ST_FILTER;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILTER: begin
                if (!samp_valid_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (samp_code_s != cand_q) begin
                    cand_d = samp_code_s;
                    cnt_d  = 4'd1;
                end else if ((cnt_q + 4'd1) == STABLE_W) begin
                    state_d = ST_ASSERT;
                    cnt_d   = 4'd0;
                    timer_d = 10'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ASSERT: begin
                // Ack has priority over a timeout landing on the same edge
                if (irq_ack) begin
                    hold_d = 4'd0;
                    if (HOLD_ZERO) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                end else if (TO_EN && (timer_q == TO_LAST)) begin
                    to_set_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + 10'd1;
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                timer_d = 10'd0;
                hold_d  = 4'd0;
            end
        endcase
    end

    // Output values as they will stand after the coming edge; sticky set beats clear
    always_comb begin
        irq_d  = (state_d == ST_ASSERT);
        vec_d  = irq_d ? cand_d : 6'd0;
        busy_d = (state_d != ST_IDLE);
        bad_d  = samp_illegal_s | (bad_q & ~err_clr);
        to_d   = to_set_s | (to_q & ~err_clr);
    end

    // Input sample, FSM state, counters and registered outputs
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            bus_q   <= 3'd0;
            chan_q  <= 4'd0;
            state_q <= ST_IDLE;
            cand_q  <= 6'd0;
            cnt_q   <= 4'd0;
            timer_q <= 10'd0;
            hold_q  <= 4'd0;
            irq_q   <= 1'b0;
            vec_q   <= 6'd0;
            busy_q  <= 1'b0;
            bad_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            bus_q   <= grant_bus;
            chan_q  <= grant_chan;
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            bad_q   <= bad_d;
            to_q    <= to_d;
        end
    end

    assign irq         = irq_q;
    assign irq_vec     = vec_q;
    assign busy        = busy_q;
    assign bad_code    = bad_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_intr_grant_sequencer.sv
// Testbench for intr_grant_sequencer: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural reference model.
module tb_intr_grant_sequencer;

    localparam int STABLE = 2;
    localparam int TO     = 64;
    localparam int HOLD   = 4;

    logic       CK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [2:0] grant_bus = 3'd0;
    logic [3:0] grant_chan = 4'd0;
    logic       irq_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic       irq;
    logic [5:0] irq_vec;
    logic       busy;
    logic       bad_code;
    logic       timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    intr_grant_sequencer #(
        .STABLE_CYCLES(STABLE),
        .ACK_TIMEOUT(TO),
        .HOLDOFF(HOLD)
    ) dut (
        .CK(CK),
        .RESET_N(RESET_N),
        .grant_bus(grant_bus),
        .grant_chan(grant_chan),
        .irq_ack(irq_ack),
        .err_clr(err_clr),
        .irq(irq),
        .irq_vec(irq_vec),
        .busy(busy),
        .bad_code(bad_code),
        .timeout_err(timeout_err)
    );

    always #5 CK = ~CK;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_WAIT = 1, M_IRQ = 2, M_QUIET = 3;
    int         m_mode;
    int         m_run;        // consecutive identical valid samples seen
    int         m_high;       // cycles irq has been high so far
    int         m_quiet_left; // holdoff cycles still to spend
    logic [5:0] m_cand;
    logic [2:0] m_bus;
    logic [3:0] m_chan;
    bit         m_bad, m_to;

    function automatic int lowest_bus(input logic [2:0] b);
        for (int i = 0; i < 3; i++) begin
            if (b[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_run = 0; m_high = 0; m_quiet_left = 0;
        m_cand = 6'd0; m_bus = 3'd0; m_chan = 4'd0; m_bad = 0; m_to = 0;
    endtask

    task automatic enter_irq();
        m_mode = M_IRQ;
        m_high = 1;
    endtask

    task automatic model_edge();
        int         li;
        bit         ill, sv, to_ev;
        logic [5:0] sc;
        li    = lowest_bus(m_bus);
        ill   = (li >= 0) && (m_chan > 4'd8);
        sv    = (li >= 0) && !ill;
        sc    = {li[1:0], m_chan};
        to_ev = 0;
        case (m_mode)
            M_IDLE: if (sv) begin
                m_cand = sc;
                m_run  = 1;
                if (m_run >= STABLE) enter_irq(); else m_mode = M_WAIT;
            end
            M_WAIT: begin
                if (!sv) m_mode = M_IDLE;
                else if (sc != m_cand) begin m_cand = sc; m_run = 1; end
                else begin
                    m_run++;
                    if (m_run >= STABLE) enter_irq();
                end
            end
            M_IRQ: begin
                if (irq_ack) begin
                    if (HOLD == 0) m_mode = M_IDLE;
                    else begin m_mode = M_QUIET; m_quiet_left = HOLD; end
                end else if (TO != 0 && m_high == TO) begin
                    to_ev = 1; m_mode = M_IDLE;
                end else m_high++;
            end
            default: begin
                m_quiet_left--;
                if (m_quiet_left == 0) m_mode = M_IDLE;
            end
        endcase
        m_bad  = ill || (m_bad && !err_clr);
        m_to   = to_ev || (m_to && !err_clr);
        m_bus  = grant_bus;
        m_chan = grant_chan;
    endtask

    task automatic check_outputs();
        bit exp_irq;
        exp_irq = (m_mode == M_IRQ);
        chk_eq("irq", irq, exp_irq);
        chk_eq("irq_vec", irq_vec, exp_irq ? m_cand : 6'd0);
        chk_eq("busy", busy, m_mode != M_IDLE);
        chk_eq("bad_code", bad_code, m_bad);
        chk_eq("timeout_err", timeout_err, m_to);
    endtask

    // One clock: advance model on the edge, compare just after it
    task automatic step();
        @(posedge CK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic [2:0] b, input logic [3:0] c);
        grant_bus  = b;
        grant_chan = c;
    endtask

    // Step until irq rises or the budget runs out; n returns steps taken
    task automatic wait_irq(input int max, output int n);
        n = 0;
        for (int i = 0; i < max; i++) begin
            step();
            n++;
            if (irq === 1'b1) break;
        end
        chk_eq("irq_rise", irq, 1'b1);
    endtask

    task automatic drain();
        drive(3'd0, 4'd0);
        irq_ack = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        steps(HOLD + 3);
    endtask

    initial begin
        int n, hi;
        model_reset();
        repeat (3) @(posedge CK);
        #1;
        chk_eq("rst_irq", irq, 1'b0);
        chk_eq("rst_vec", irq_vec, 6'd0);
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_bad", bad_code, 1'b0);
        chk_eq("rst_to", timeout_err, 1'b0);
        @(negedge CK);
        RESET_N = 1'b1;

        // 1: basic handshake with holdoff
        drive(3'b010, 4'd5);
        wait_irq(10, n);
        chk_eq("t1_latency", n, STABLE + 1);
        chk_eq("t1_vec", irq_vec, 6'b01_0101);
        chk_eq("t1_busy", busy, 1'b1);
        steps(3);
        irq_ack = 1'b1;
        drive(3'd0, 4'd0);
        step();
        irq_ack = 1'b0;
        chk_eq("t1_irq_fall", irq, 1'b0);
        chk_eq("t1_holdoff_busy", busy, 1'b1);
        steps(HOLD - 1);
        chk_eq("t1_holdoff_end_busy", busy, 1'b1);
        step();
        chk_eq("t1_idle", busy, 1'b0);
        drain();

        // 2: one-cycle glitch followed by a stable code
        drive(3'b001, 4'd2);
        step();
        drive(3'b100, 4'd7);
        wait_irq(10, n);
        chk_eq("t2_latency", n, STABLE + 1);
        chk_eq("t2_vec", irq_vec, 6'b10_0111);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        drain();

        // 3: bus priority, plus upstream change during ASSERT
        drive(3'b110, 4'd0);
        wait_irq(10, n);
        chk_eq("t3_vec", irq_vec, 6'b01_0000);
        drive(3'b001, 4'd8);
        steps(3);
        chk_eq("t3_vec_held", irq_vec, 6'b01_0000);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        drain();

        // 4: illegal channel code
        drive(3'b001, 4'd12);
        step();
        drive(3'd0, 4'd0);
        step();
        chk_eq("t4_bad", bad_code, 1'b1);
        chk_eq("t4_irq", irq, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk_eq("t4_bad_clr", bad_code, 1'b0);
        drain();

        // 5a: timeout, irq high exactly TO cycles
        drive(3'b001, 4'd3);
        wait_irq(10, n);
        hi = 1;
        for (int i = 0; i < 3 * TO; i++) begin
            step();
            if (irq === 1'b1) hi++;
            else break;
        end
        chk_eq("t5_high_cycles", hi, TO);
        chk_eq("t5_to_err", timeout_err, 1'b1);
        chk_eq("t5_busy", busy, 1'b0);
        drain();
        chk_eq("t5_to_clr", timeout_err, 1'b0);

        // 5b: ack on the final cycle beats the timeout
        drive(3'b001, 4'd3);
        wait_irq(10, n);
        steps(TO - 1);
        chk_eq("t5b_still_high", irq, 1'b1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk_eq("t5b_to_err", timeout_err, 1'b0);
        chk_eq("t5b_holdoff", busy, 1'b1);
        chk_eq("t5b_irq", irq, 1'b0);
        drain();

        // 6: asynchronous reset mid-ASSERT
        drive(3'b100, 4'd1);
        wait_irq(10, n);
        #3;
        RESET_N = 1'b0;
        #1;
        chk_eq("t6_irq_async", irq, 1'b0);
        chk_eq("t6_vec_async", irq_vec, 6'd0);
        chk_eq("t6_busy_async", busy, 1'b0);
        model_reset();
        repeat (2) @(posedge CK);
        @(negedge CK);
        RESET_N = 1'b1;
        wait_irq(10, n);
        chk_eq("t6_relatency", n, STABLE + 1);
        chk_eq("t6_vec", irq_vec, 6'b10_0001);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        drain();

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 30) begin
                grant_bus = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) grant_chan = 4'($urandom_range(9, 15));
                else grant_chan = 4'($urandom_range(0, 8));
            end
            irq_ack = ($urandom_range(0, 99) < 15);
            err_clr = ($urandom_range(0, 99) < 5);
            step();
        end
        irq_ack = 1'b0;
        err_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
